// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator core and its divider.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4
    } opcode_e;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_ENTRY_A,
        ST_ENTRY_B,
        ST_EXEC,
        ST_SHOW,
        ST_ERR
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Keypad codes outside ADD..DIV are treated as no key press.
    function automatic logic op_valid(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd4);
    endfunction

endpackage

// File: rtl/calculator_core_if.sv
// Keypad-to-core-to-display bundle: pulse keys in, signed display value and status flags out.
// Latency: wires only, no storage.
// Backpressure: none; keys are single-cycle pulses and the core drops what it cannot use (busy).
// master = keypad/display side, slave = calculator_core.
interface calculator_core_if #(
    parameter int WIDTH = 32
);
    logic             pwr;
    logic             clr;
    logic             digit_vld;
    logic [3:0]       digit;
    logic             neg;
    logic             op_vld;
    logic [2:0]       opcode;
    logic             eq_vld;
    logic [WIDTH-1:0] display;
    logic             busy;
    logic             err;
    logic             ovf;

    modport master (
        output pwr, clr, digit_vld, digit, neg, op_vld, opcode, eq_vld,
        input  display, busy, err, ovf
    );

    modport slave (
        input  pwr, clr, digit_vld, digit, neg, op_vld, opcode, eq_vld,
        output display, busy, err, ovf
    );
endinterface

// File: rtl/calc_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Latency: done_o pulses WIDTH cycles after start_i; the first step runs in the start cycle.
// Backpressure: none; abort_i returns it to idle immediately, start_i restarts it at any time.
// Ports: start_i/abort_i control, dividend_i/divisor_i sampled on start_i, quot_o valid with done_o.
module calc_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_src, quo_src, dvs_src, rem_nxt, quo_nxt;
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic             ge;
    logic [CW-1:0]    cnt_q;
    logic             run_q, done_q;

    always_comb begin
        // On start the first step works straight from the inputs.
        rem_src = start_i ? '0         : rem_q;
        quo_src = start_i ? dividend_i : quo_q;
        dvs_src = start_i ? divisor_i  : dvs_q;
        rem_sh  = {rem_src, quo_src[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dvs_src};
        // No borrow out of the extra top bit means rem_sh >= divisor.
        ge      = ~rem_sub[WIDTH];
        rem_nxt = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt = {quo_src[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (abort_i) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= rem_nxt;
            quo_q  <= quo_nxt;
            dvs_q  <= divisor_i;
            cnt_q  <= CW'(1);
            run_q  <= (WIDTH > 1);
            done_q <= (WIDTH == 1);
        end else if (run_q) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end else begin
                done_q <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign quot_o = quo_q;
    assign done_o = done_q & ~abort_i;
endmodule

// File: rtl/calculator_core.sv
// Keypad calculator: decimal entry, sign toggle, chained ADD/SUB/MUL/DIV with saturation and div-by-zero error.
// Latency: eq_vld -> display 2 cycles (ADD/SUB/MUL), WIDTH+2 cycles (DIV).
// Backpressure: none; keys other than clr/pwr arriving while busy are dropped.
// Ports: clk, rst_n (async, active-low); bus = calculator_core_if.slave (keys in, display/busy/err/ovf out).
module calculator_core
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    calculator_core_if.slave bus
);
    localparam int               NW    = $clog2(MAX_DIGITS + 1);
    localparam logic [NW-1:0]    NDMAX = NW'(MAX_DIGITS);
    localparam logic [WIDTH-1:0] SMAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN  = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    opcode_e          op_q, op_d, nop_q, nop_d;
    logic             chain_q, chain_d, dstart_q, dstart_d, eneg_q, eneg_d;
    logic             err_q, err_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] a_q, a_d, mag_q, mag_d, disp_q, disp_d;
    logic [NW-1:0]    ndig_q, ndig_d;

    logic                    div_start, div_abort, div_done, dneg, fits, sat_ovf;
    logic [WIDTH-1:0]        b_val, a_mag, quot, sat_val, mag_app, neg_a, dig_ext;
    logic signed [2*WIDTH-1:0] a_w, b_w, q_w, res_w;

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m, input logic n);
        return n ? -m : m;
    endfunction

    calc_divider #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .abort_i    (div_abort),
        .dividend_i (a_mag),
        .divisor_i  (mag_q),
        .quot_o     (quot),
        .done_o     (div_done)
    );

    // Datapath: b is the current entry; everything is evaluated at double width then saturated.
    always_comb begin
        b_val   = apply_sign(mag_q, eneg_q);
        a_mag   = apply_sign(a_q, a_q[WIDTH-1]);
        dneg    = a_q[WIDTH-1] ^ eneg_q;
        a_w     = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q});
        b_w     = $signed({{WIDTH{b_val[WIDTH-1]}}, b_val});
        q_w     = $signed({{WIDTH{1'b0}}, quot});
        case (op_q)
            OP_ADD:  res_w = a_w + b_w;
            OP_SUB:  res_w = a_w - b_w;
            OP_MUL:  res_w = a_w * b_w;
            OP_DIV:  res_w = dneg ? -q_w : q_w;
            default: res_w = a_w;
        endcase
        fits    = (res_w[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){res_w[WIDTH-1]}});
        sat_ovf = ~fits;
        sat_val = fits ? res_w[WIDTH-1:0] : (res_w[2*WIDTH-1] ? SMIN : SMAX);
        dig_ext = {{(WIDTH-4){1'b0}}, bus.digit};
        mag_app = (mag_q << 3) + (mag_q << 1) + dig_ext;
        neg_a   = (a_q == SMIN) ? SMAX : -a_q;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        op_d      = op_q;
        nop_d     = nop_q;
        chain_d   = chain_q;
        dstart_d  = dstart_q;
        mag_d     = mag_q;
        eneg_d    = eneg_q;
        ndig_d    = ndig_q;
        disp_d    = disp_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        div_start = 1'b0;
        div_abort = 1'b0;
        if (!bus.pwr || (bus.clr && state_q != ST_OFF)) begin
            state_d   = bus.pwr ? ST_ENTRY_A : ST_OFF;
            a_d       = '0;
            op_d      = OP_NONE;
            nop_d     = OP_NONE;
            chain_d   = 1'b0;
            dstart_d  = 1'b0;
            mag_d     = '0;
            eneg_d    = 1'b0;
            ndig_d    = '0;
            disp_d    = '0;
            err_d     = 1'b0;
            ovf_d     = 1'b0;
            div_abort = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_ENTRY_A;
                ST_EXEC: begin
                    if (op_q == OP_DIV && mag_q == '0) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        disp_d  = '0;
                        chain_d = 1'b0;
                    end else if (op_q == OP_DIV && !dstart_q) begin
                        div_start = 1'b1;
                        dstart_d  = 1'b1;
                    end else if (op_q != OP_DIV || div_done) begin
                        // Result becomes the new a; a pending chained op goes straight back to entry.
                        a_d      = sat_val;
                        disp_d   = sat_val;
                        ovf_d    = sat_ovf;
                        dstart_d = 1'b0;
                        mag_d    = '0;
                        eneg_d   = 1'b0;
                        ndig_d   = '0;
                        if (chain_q) begin
                            op_d    = nop_q;
                            chain_d = 1'b0;
                            state_d = ST_ENTRY_B;
                        end else begin
                            state_d = ST_SHOW;
                        end
                    end
                end
                ST_ENTRY_A, ST_ENTRY_B, ST_SHOW: begin
                    if (bus.eq_vld) begin
                        if (state_q == ST_ENTRY_B) begin
                            state_d = ST_EXEC;
                            chain_d = 1'b0;
                        end
                    end else if (bus.op_vld) begin
                        if (op_valid(bus.opcode)) begin
                            if (state_q == ST_ENTRY_A) begin
                                a_d     = b_val;
                                disp_d  = b_val;
                                op_d    = opcode_e'(bus.opcode);
                                mag_d   = '0;
                                eneg_d  = 1'b0;
                                ndig_d  = '0;
                                state_d = ST_ENTRY_B;
                            end else if (state_q == ST_SHOW || ndig_q == '0) begin
                                op_d    = opcode_e'(bus.opcode);
                                state_d = ST_ENTRY_B;
                            end else begin
                                nop_d   = opcode_e'(bus.opcode);
                                chain_d = 1'b1;
                                state_d = ST_EXEC;
                            end
                        end
                    end else if (bus.neg) begin
                        if (state_q == ST_SHOW) begin
                            a_d    = neg_a;
                            disp_d = neg_a;
                            ovf_d  = ovf_q | (a_q == SMIN);
                        end else begin
                            eneg_d = ~eneg_q;
                            // In ENTRY_B the display keeps showing a until a digit arrives.
                            if (state_q == ST_ENTRY_A || ndig_q != '0)
                                disp_d = apply_sign(mag_q, ~eneg_q);
                        end
                    end else if (bus.digit_vld && bus.digit <= BCD_MAX) begin
                        ovf_d = 1'b0;
                        if (state_q == ST_SHOW) begin
                            a_d     = '0;
                            mag_d   = dig_ext;
                            eneg_d  = 1'b0;
                            ndig_d  = NW'(1);
                            disp_d  = dig_ext;
                            state_d = ST_ENTRY_A;
                        end else if (ndig_q < NDMAX) begin
                            mag_d  = mag_app;
                            ndig_d = ndig_q + NW'(1);
                            disp_d = apply_sign(mag_app, eneg_q);
                        end
                    end
                end
                ST_ERR: ;
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            a_q      <= '0;
            op_q     <= OP_NONE;
            nop_q    <= OP_NONE;
            chain_q  <= 1'b0;
            dstart_q <= 1'b0;
            mag_q    <= '0;
            eneg_q   <= 1'b0;
            ndig_q   <= '0;
            disp_q   <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            op_q     <= op_d;
            nop_q    <= nop_d;
            chain_q  <= chain_d;
            dstart_q <= dstart_d;
            mag_q    <= mag_d;
            eneg_q   <= eneg_d;
            ndig_q   <= ndig_d;
            disp_q   <= disp_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.display = disp_q;
    assign bus.busy    = (state_q == ST_EXEC);
    assign bus.err     = err_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_calculator_core.sv
module tb_calculator_core;
    import calc_pkg::*;

    localparam int W       = 32;
    localparam int DIV_BSY = W + 1;
    localparam int SMAXI   = 2147483647;
    localparam int SMINI   = -2147483647 - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    calculator_core_if #(.WIDTH(W)) bus_if ();
    calculator_core #(.WIDTH(W), .MAX_DIGITS(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned a;
        bit          an;
        opcode_e     opc;
        int unsigned b;
        bit          bn;
        int          exp_d;
        bit          exp_ovf;
        bit          exp_err;
        int          exp_busy;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_digit(input logic [3:0] d);
        tick();
        bus_if.digit = d;
        bus_if.digit_vld = 1'b1;
        tick();
        bus_if.digit_vld = 1'b0;
    endtask

    task automatic press_op(input logic [2:0] o);
        tick();
        bus_if.opcode = o;
        bus_if.op_vld = 1'b1;
        tick();
        bus_if.op_vld = 1'b0;
    endtask

    task automatic press_neg();
        tick();
        bus_if.neg = 1'b1;
        tick();
        bus_if.neg = 1'b0;
    endtask

    task automatic press_eq();
        tick();
        bus_if.eq_vld = 1'b1;
        tick();
        bus_if.eq_vld = 1'b0;
    endtask

    task automatic press_clr();
        tick();
        bus_if.clr = 1'b1;
        tick();
        bus_if.clr = 1'b0;
    endtask

    task automatic enter_num(input int unsigned v, input bit ng);
        int unsigned digs[$];
        int unsigned t;
        t = v;
        do begin
            digs.push_front(t % 10);
            t = t / 10;
        end while (t != 0);
        foreach (digs[i]) press_digit(4'(digs[i]));
        if (ng) press_neg();
    endtask

    // Counts cycles busy stays high, bounded so a stuck DUT still ends the run.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus_if.busy && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic start_div_100_7();
        press_clr();
        enter_num(100, 1'b0);
        press_op(OP_DIV);
        enter_num(7, 1'b0);
        press_eq();
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{123,       1'b0, OP_ADD, 45,        1'b0, 168,        1'b0, 1'b0, 1};
        vecs[1]  = '{7,         1'b1, OP_SUB, 3,         1'b0, -10,        1'b0, 1'b0, 1};
        vecs[2]  = '{100,       1'b0, OP_DIV, 7,         1'b0, 14,         1'b0, 1'b0, DIV_BSY};
        vecs[3]  = '{100,       1'b1, OP_DIV, 7,         1'b0, -14,        1'b0, 1'b0, DIV_BSY};
        vecs[4]  = '{100,       1'b0, OP_DIV, 7,         1'b1, -14,        1'b0, 1'b0, DIV_BSY};
        vecs[5]  = '{999999999, 1'b0, OP_MUL, 9,         1'b0, SMAXI,      1'b1, 1'b0, 1};
        vecs[6]  = '{999999999, 1'b1, OP_MUL, 9,         1'b0, SMINI,      1'b1, 1'b0, 1};
        vecs[7]  = '{999999999, 1'b1, OP_MUL, 3,         1'b1, SMAXI,      1'b1, 1'b0, 1};
        vecs[8]  = '{999999999, 1'b0, OP_SUB, 999999999, 1'b1, 1999999998, 1'b0, 1'b0, 1};
        vecs[9]  = '{7,         1'b0, OP_DIV, 9,         1'b0, 0,          1'b0, 1'b0, DIV_BSY};
        vecs[10] = '{999999999, 1'b1, OP_DIV, 7,         1'b1, 142857142,  1'b0, 1'b0, DIV_BSY};
        vecs[11] = '{5,         1'b0, OP_DIV, 0,         1'b0, 0,          1'b0, 1'b1, 1};
        vecs[12] = '{65535,     1'b0, OP_MUL, 32767,     1'b0, 2147385345, 1'b0, 1'b0, 1};
        vecs[13] = '{46341,     1'b0, OP_MUL, 46341,     1'b0, SMAXI,      1'b1, 1'b0, 1};

        bus_if.pwr = 1'b1;
        bus_if.clr = 1'b0;
        bus_if.digit_vld = 1'b0;
        bus_if.digit = 4'd0;
        bus_if.neg = 1'b0;
        bus_if.op_vld = 1'b0;
        bus_if.opcode = 3'd0;
        bus_if.eq_vld = 1'b0;

        #2 rst_n = 1'b0;
        tick();
        tick();
        check("reset_display", $signed(bus_if.display), 0);
        check("reset_busy", bus_if.busy, 0);
        check("reset_err", bus_if.err, 0);
        check("reset_ovf", bus_if.ovf, 0);
        rst_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 14; i++) begin
            press_clr();
            enter_num(vecs[i].a, vecs[i].an);
            press_op(vecs[i].opc);
            enter_num(vecs[i].b, vecs[i].bn);
            press_eq();
            wait_idle(cyc);
            check($sformatf("v%0d_busy_cycles", i), cyc, vecs[i].exp_busy);
            check($sformatf("v%0d_display", i), $signed(bus_if.display), vecs[i].exp_d);
            check($sformatf("v%0d_ovf", i), bus_if.ovf, vecs[i].exp_ovf);
            check($sformatf("v%0d_err", i), bus_if.err, vecs[i].exp_err);
        end

        // Result reused as a, then negated in SHOW.
        press_clr();
        enter_num(7, 1'b1);
        press_op(OP_SUB);
        enter_num(3, 1'b0);
        press_eq();
        wait_idle(cyc);
        check("reuse_first", $signed(bus_if.display), -10);
        press_op(OP_MUL);
        check("reuse_hold_a", $signed(bus_if.display), -10);
        enter_num(2, 1'b0);
        check("reuse_b_shown", $signed(bus_if.display), 2);
        press_eq();
        wait_idle(cyc);
        check("reuse_second", $signed(bus_if.display), -20);
        press_neg();
        check("show_neg", $signed(bus_if.display), 20);

        // Digits held during the division are ignored.
        press_clr();
        enter_num(100, 1'b0);
        press_op(OP_DIV);
        enter_num(7, 1'b0);
        press_eq();
        cyc = 0;
        bus_if.digit = 4'd5;
        bus_if.digit_vld = 1'b1;
        while (bus_if.busy && cyc < 200) begin
            tick();
            cyc++;
        end
        bus_if.digit_vld = 1'b0;
        check("div_busy_digits_cycles", cyc, DIV_BSY);
        check("div_busy_digits_display", $signed(bus_if.display), 14);

        // Divide by zero, stuck in ERR until clr.
        press_clr();
        enter_num(5, 1'b0);
        press_op(OP_DIV);
        enter_num(0, 1'b0);
        press_eq();
        wait_idle(cyc);
        check("dz_err", bus_if.err, 1);
        check("dz_display", $signed(bus_if.display), 0);
        press_digit(4'd3);
        check("dz_digit_ignored", $signed(bus_if.display), 0);
        check("dz_err_held", bus_if.err, 1);
        press_clr();
        check("dz_clr_err", bus_if.err, 0);
        check("dz_clr_display", $signed(bus_if.display), 0);
        press_digit(4'd8);
        check("dz_entry_a", $signed(bus_if.display), 8);

        // Overflow flag clears on the next digit.
        press_clr();
        enter_num(999999999, 1'b0);
        press_op(OP_MUL);
        enter_num(9, 1'b0);
        press_eq();
        wait_idle(cyc);
        check("ovf_set", bus_if.ovf, 1);
        press_digit(4'd4);
        check("ovf_cleared", bus_if.ovf, 0);
        check("ovf_new_entry", $signed(bus_if.display), 4);

        // Operator chaining.
        press_clr();
        enter_num(2, 1'b0);
        press_op(OP_ADD);
        enter_num(3, 1'b0);
        press_op(OP_MUL);
        wait_idle(cyc);
        check("chain_busy", cyc, 1);
        check("chain_partial", $signed(bus_if.display), 5);
        enter_num(4, 1'b0);
        press_eq();
        wait_idle(cyc);
        check("chain_final", $signed(bus_if.display), 20);

        // MIN / -1 saturates to MAX.
        press_clr();
        enter_num(999999999, 1'b1);
        press_op(OP_MUL);
        enter_num(9, 1'b0);
        press_eq();
        wait_idle(cyc);
        check("min_made", $signed(bus_if.display), SMINI);
        press_op(OP_DIV);
        enter_num(1, 1'b1);
        press_eq();
        wait_idle(cyc);
        check("min_div_m1", $signed(bus_if.display), SMAXI);
        check("min_div_m1_ovf", bus_if.ovf, 1);
        check("min_div_m1_busy", cyc, DIV_BSY);

        // Tenth digit ignored.
        press_clr();
        enter_num(1234567891, 1'b0);
        check("max_digits", $signed(bus_if.display), 123456789);

        // Asynchronous reset mid-division.
        start_div_100_7();
        repeat (5) tick();
        check("rst_mid_busy_before", bus_if.busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_display", $signed(bus_if.display), 0);
        check("rst_mid_busy", bus_if.busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        press_digit(4'd6);
        check("rst_then_entry", $signed(bus_if.display), 6);

        // Power drop mid-division.
        start_div_100_7();
        repeat (5) tick();
        bus_if.pwr = 1'b0;
        tick();
        check("pwr_off_display", $signed(bus_if.display), 0);
        check("pwr_off_busy", bus_if.busy, 0);
        bus_if.pwr = 1'b1;
        tick();
        press_digit(4'd9);
        check("pwr_on_entry", $signed(bus_if.display), 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
